// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer (master) and imem (slave).
interface pc_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;

  modport master (output req, output addr, input ack);
  modport slave  (input req, input addr, output ack);
endinterface

// File: rtl/pc_sequencer.sv
// IF-stage controller: owns the PC, runs the imem req/ack handshake and arbitrates
// branch/jal redirects, hazard stalls and halt; redirects seen while a fetch waits are parked.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_hazard_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        jal_valid_i,
  input  logic [31:0] jal_target_i,
  input  logic        halt_req_i,
  pc_sequencer_if.master imem,
  output logic [31:0] pc_out_o,
  output logic        if_valid_o,
  output logic        PCWrite_o,
  output logic        IFID_flush_o,
  output logic        IDEX_flush_o,
  output logic        misalign_o,
  output logic        halted_o
);

  typedef enum logic [1:0] {BOOT, FETCH, WAIT, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_is_br_q, pend_is_br_d;
  logic        misalign_q, misalign_d;

  logic        active, ack;
  logic [31:0] br_al, jal_al;

  assign active = (state_q == FETCH) || (state_q == WAIT);
  assign ack    = active && imem.ack;
  assign br_al  = {br_target_i[31:2], 2'b00};
  assign jal_al = {jal_target_i[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BOOT;
    else     state_q <= state_d;
  end

  // A taken branch in the same cycle wins over halt: the halting instruction is on the wrong path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:        state_d = FETCH;
      FETCH, WAIT: begin
        if (halt_req_i && !br_taken_i) state_d = HALT;
        else if (ack)                  state_d = FETCH;
        else                           state_d = WAIT;
      end
      default:     state_d = HALT;
    endcase
  end

  always_comb begin
    imem.req     = active;
    imem.addr    = pc_q;
    if_valid_o   = ack && !br_taken_i && !pend_valid_q && !jal_valid_i && !stall_hazard_i;
    PCWrite_o    = ack && (br_taken_i || pend_valid_q || jal_valid_i || !stall_hazard_i);
    IFID_flush_o = active && (br_taken_i || jal_valid_i);
    IDEX_flush_o = active && br_taken_i;
    halted_o     = (state_q == HALT);
  end

  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pend_is_br_d  = pend_is_br_q;
    misalign_d    = 1'b0;
    if (ack) begin
      // Any redirect accepted with ack retires the parked target as well.
      if (br_taken_i) begin
        pc_d         = br_al;
        pend_valid_d = 1'b0;
        misalign_d   = |br_target_i[1:0];
      end else if (pend_valid_q) begin
        pc_d         = pend_target_q;
        pend_valid_d = 1'b0;
      end else if (jal_valid_i) begin
        pc_d       = jal_al;
        misalign_d = |jal_target_i[1:0];
      end else if (!stall_hazard_i) begin
        pc_d = pc_q + 32'd4;
      end
    end else if (active) begin
      if (br_taken_i) begin
        pend_valid_d  = 1'b1;
        pend_target_d = br_al;
        pend_is_br_d  = 1'b1;
        misalign_d    = |br_target_i[1:0];
      end else if (jal_valid_i && !(pend_valid_q && pend_is_br_q)) begin
        pend_valid_d  = 1'b1;
        pend_target_d = jal_al;
        pend_is_br_d  = 1'b0;
        misalign_d    = |jal_target_i[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      pend_is_br_q  <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      pend_is_br_q  <= pend_is_br_d;
      misalign_q    <= misalign_d;
    end
  end

  assign pc_out_o   = pc_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Random + directed bench for pc_sequencer against a fetch-level reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_hazard = 1'b0, br_taken = 1'b0, jal_valid = 1'b0, halt_req = 1'b0;
  logic [31:0] br_target = 32'h0, jal_target = 32'h0;
  logic [31:0] pc_out;
  logic        if_valid, PCWrite, IFID_flush, IDEX_flush, misalign, halted;

  pc_sequencer_if imem_if();

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .stall_hazard_i(stall_hazard), .br_taken_i(br_taken), .br_target_i(br_target),
    .jal_valid_i(jal_valid), .jal_target_i(jal_target), .halt_req_i(halt_req),
    .imem(imem_if),
    .pc_out_o(pc_out), .if_valid_o(if_valid), .PCWrite_o(PCWrite),
    .IFID_flush_o(IFID_flush), .IDEX_flush_o(IDEX_flush),
    .misalign_o(misalign), .halted_o(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = boot cycle, 1 = fetching (waiting or not), 2 = halted.
  int          mphase;
  logic [31:0] mpc, mpt;
  bit          mpv, mpbr, mmis;
  bit          last_ifv, last_ifl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    stall_hazard = 0; br_taken = 0; jal_valid = 0; halt_req = 0; imem_if.ack = 0;
    #1;
    chk("rst_req", {31'h0, imem_if.req}, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_ifv_pcw", {30'h0, if_valid, PCWrite}, 32'h0);
    chk("rst_flush", {30'h0, IFID_flush, IDEX_flush}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    mphase = 0; mpc = 32'h0; mpt = 32'h0; mpv = 0; mpbr = 0; mmis = 0;
  endtask

  // One clock cycle: apply inputs, compare outputs at negedge, advance model after posedge.
  task automatic step(input bit a, input bit br, input bit jal, input bit st, input bit hlt,
                      input logic [31:0] bt, input logic [31:0] jt);
    bit fetching, acc;
    int          nphase;
    logic [31:0] npc, npt;
    bit          npv, npbr, nmis;
    imem_if.ack = a; br_taken = br; jal_valid = jal; stall_hazard = st; halt_req = hlt;
    br_target = bt; jal_target = jt;
    @(negedge clk);
    fetching = (mphase == 1);
    acc = fetching && a;
    chk("req", {31'h0, imem_if.req}, {31'h0, fetching});
    chk("addr", imem_if.addr, mpc);
    chk("pc", pc_out, mpc);
    chk("if_valid", {31'h0, if_valid}, {31'h0, acc && !br && !mpv && !jal && !st});
    chk("PCWrite", {31'h0, PCWrite}, {31'h0, acc && (br || mpv || jal || !st)});
    chk("IFID_flush", {31'h0, IFID_flush}, {31'h0, fetching && (br || jal)});
    chk("IDEX_flush", {31'h0, IDEX_flush}, {31'h0, fetching && br});
    chk("halted", {31'h0, halted}, {31'h0, mphase == 2});
    chk("misalign", {31'h0, misalign}, {31'h0, mmis});
    last_ifv = if_valid; last_ifl = IFID_flush;
    nphase = mphase; npc = mpc; npt = mpt; npv = mpv; npbr = mpbr; nmis = 0;
    if (mphase == 0) nphase = 1;
    else if (fetching) begin
      if (a) begin
        if (br)       begin npc = bt & ~32'h3; npv = 0; nmis = (bt % 4) != 0; end
        else if (mpv) begin npc = mpt; npv = 0; end
        else if (jal) begin npc = jt & ~32'h3; nmis = (jt % 4) != 0; end
        else if (!st) npc = mpc + 32'd4;
      end else if (br) begin
        npt = bt & ~32'h3; npv = 1; npbr = 1; nmis = (bt % 4) != 0;
      end else if (jal && !(mpv && mpbr)) begin
        npt = jt & ~32'h3; npv = 1; npbr = 0; nmis = (jt % 4) != 0;
      end
      if (hlt && !br) nphase = 2;
    end
    @(posedge clk);
    #1;
    mphase = nphase; mpc = npc; mpt = npt; mpv = npv; mpbr = npbr; mmis = nmis;
  endtask

  task automatic idle(input bit a);
    step(a, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    imem_if.ack = 1'b0;
    // Zero-wait sequential fetch.
    do_reset();
    idle(0);
    chk("boot_pc", pc_out, 32'h0);
    idle(1); chk("seq_pc4", pc_out, 32'h4);
    chk("first_ack_ifv", {31'h0, last_ifv}, 32'h1);
    idle(1); chk("seq_pc8", pc_out, 32'h8);
    idle(1); chk("seq_pcC", pc_out, 32'hC);

    // Three wait cycles at pc=8.
    do_reset(); idle(0); idle(1); idle(1);
    for (int i = 0; i < 3; i++) begin
      idle(0); chk("wait_addr", imem_if.addr, 32'h8);
    end
    idle(1); chk("wait_done_pc", pc_out, 32'hC);

    // Branch during WAIT at 0x10, ack two cycles later.
    do_reset(); idle(0);
    for (int i = 0; i < 4; i++) idle(1);
    chk("br_start_pc", pc_out, 32'h10);
    idle(0);
    step(0, 1, 0, 0, 0, 32'h40, 32'h0);
    chk("br_flush", {31'h0, last_ifl}, 32'h1);
    idle(0);
    idle(1);
    chk("br_ack_ifv", {31'h0, last_ifv}, 32'h0);
    chk("br_pc", pc_out, 32'h40);

    // jal beats stall.
    step(1, 0, 1, 1, 0, 32'h0, 32'h100);
    chk("jal_pc", pc_out, 32'h100);
    chk("jal_flush", {31'h0, last_ifl}, 32'h1);
    chk("jal_ifv", {31'h0, last_ifv}, 32'h0);

    // Misaligned branch target.
    step(1, 1, 0, 0, 0, 32'h42, 32'h0);
    chk("mis_pc", pc_out, 32'h40);
    chk("mis_pulse", {31'h0, misalign}, 32'h1);
    idle(1);
    chk("mis_clear", {31'h0, misalign}, 32'h0);

    // PC wrap.
    step(1, 0, 1, 0, 0, 32'h0, 32'hFFFF_FFFC);
    idle(1); chk("wrap_pc", pc_out, 32'h0);

    // Halt at 0x20.
    step(1, 0, 1, 0, 0, 32'h0, 32'h20);
    step(0, 0, 0, 0, 1, 32'h0, 32'h0);
    chk("halt_halted", {31'h0, halted}, 32'h1);
    chk("halt_req", {31'h0, imem_if.req}, 32'h0);
    for (int i = 0; i < 3; i++) idle(1);
    chk("halt_pc", pc_out, 32'h20);
    do_reset();
    chk("halt_rst_pc", pc_out, 32'h0);

    // Reset while a redirect is parked.
    idle(0); idle(1);
    step(0, 0, 1, 0, 0, 32'h0, 32'h80);
    do_reset(); idle(0); idle(1);
    chk("pend_cleared_pc", pc_out, 32'h4);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] bt, jt;
      if ((mphase == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
        do_reset();
      bt = $urandom(); jt = $urandom();
      if ($urandom_range(0, 1) == 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) jt[1:0] = 2'b00;
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 39) == 0, bt, jt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
